deserializer: RTL and testbench

Serial-to-parallel receiver: the receive end of the LSB-first framed serial link driven by the team's serializer.
- Samples serial_in on every clock where serial_valid is high. serial_valid connects to the transmitter's busy.
- Assembles DATA_WIDTH bits into a word and holds it in an output buffer until the consumer acknowledges it.
- Flags truncated frames and unacknowledged overwrites.

---
 rtl/deserializer.sv | 110 +++++++++++
 tb/tb_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver for the LSB-first framed serial link.
// Collects DATA_WIDTH bits per frame into an output buffer held until acknowledged.
module deserializer #(
  parameter  int DATA_WIDTH   = 8,
  localparam int COUNTER_SIZE = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [COUNTER_SIZE-1:0] LAST_BIT = COUNTER_SIZE'(DATA_WIDTH - 1);

  state_t                  r_state, w_nextState;
  logic [COUNTER_SIZE-1:0] r_count, w_nextCount;
  logic [DATA_WIDTH-1:0]   r_shreg, w_nextShreg;
  logic [DATA_WIDTH-1:0]   r_dataOut, w_nextDataOut;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic                    r_dataValid, w_nextDataValid;
  logic                    r_frameError, w_nextFrameError;
  logic                    r_overrun, w_nextOverrun;

  assign w_shifted = {serial_in, r_shreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_shreg      <= '0;
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_frameError <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_shreg      <= w_nextShreg;
      r_dataOut    <= w_nextDataOut;
      r_dataValid  <= w_nextDataValid;
      r_frameError <= w_nextFrameError;
      r_overrun    <= w_nextOverrun;
    end
  end

  always_comb begin
    w_nextState      = r_state;
    w_nextCount      = r_count;
    w_nextShreg      = r_shreg;
    w_nextDataOut    = r_dataOut;
    w_nextDataValid  = r_dataValid;
    w_nextFrameError = 1'b0;
    w_nextOverrun    = r_overrun;

    // A completing frame below overrides this clear, so a same-edge ack keeps the new word valid.
    if (data_ack && r_dataValid) begin
      w_nextDataValid = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (serial_valid) begin
          w_nextShreg = w_shifted;
          w_nextCount = COUNTER_SIZE'(1);
          w_nextState = RECV;
        end
      end
      RECV: begin
        if (serial_valid) begin
          if (r_count == LAST_BIT) begin
            w_nextDataOut   = w_shifted;
            w_nextDataValid = 1'b1;
            if (r_dataValid && !data_ack) begin
              w_nextOverrun = 1'b1;
            end
            w_nextShreg = '0;
            w_nextCount = '0;
            w_nextState = IDLE;
          end else begin
            w_nextShreg = w_shifted;
            w_nextCount = r_count + COUNTER_SIZE'(1);
          end
        end else begin
          w_nextFrameError = 1'b1;
          w_nextShreg      = '0;
          w_nextCount      = '0;
          w_nextState      = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign data_out    = r_dataOut;
  assign data_valid  = r_dataValid;
  assign busy        = (r_state == RECV);
  assign frame_error = r_frameError;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: a bit-collecting reference model checked every cycle,
// plus directed frames with hand-computed expected words and flags.
module tb_deserializer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         serial_in = 1'b1;
  logic         serial_valid = 1'b0;
  logic         data_ack = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_error;
  logic         overrun;

  int nVectors = 0;
  int nMiscompares = 0;

  deserializer #(.DATA_WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .data_ack     (data_ack),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Reference model: collects bits by index, publishes the word once W bits have arrived.
  int           mBits  = 0;
  logic [W-1:0] mWord  = '0;
  logic [W-1:0] mOut   = '0;
  logic         mValid = 1'b0;
  logic         mErr   = 1'b0;
  logic         mOvr   = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mBits  = 0;
      mWord  = '0;
      mOut   = '0;
      mValid = 1'b0;
      mErr   = 1'b0;
      mOvr   = 1'b0;
    end else begin
      logic ackNow;
      ackNow = data_ack && mValid;
      mErr   = 1'b0;
      if (serial_valid) begin
        mWord[mBits] = serial_in;
        mBits++;
        if (mBits == W) begin
          if (mValid && !data_ack) mOvr = 1'b1;
          mOut   = mWord;
          mValid = 1'b1;
          mBits  = 0;
          mWord  = '0;
        end else if (ackNow) begin
          mValid = 1'b0;
        end
      end else begin
        if (mBits > 0) begin
          mErr  = 1'b1;
          mBits = 0;
          mWord = '0;
        end
        if (ackNow) mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("model data_out",    32'(data_out),    32'(mOut));
    checkOutput("model data_valid",  32'(data_valid),  32'(mValid));
    checkOutput("model busy",        32'(busy),        32'(mBits > 0));
    checkOutput("model frame_error", 32'(frame_error), 32'(mErr));
    checkOutput("model overrun",     32'(overrun),     32'(mOvr));
  end

  task automatic applyStimulus(input logic sv, input logic si, input logic ack);
    @(posedge clock);
    #1;
    serial_valid = sv;
    serial_in    = si;
    data_ack     = ack;
  endtask

  task automatic sendWord(input logic [W-1:0] word, input logic ackLast);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b1, word[i], (i == W - 1) ? ackLast : 1'b0);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #1;
    reset        = 1'b0;
    serial_valid = 1'b0;
    serial_in    = 1'b1;
    data_ack     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with an active-looking frame strobe: nothing may be captured.
    reset        = 1'b0;
    serial_in    = 1'b0;
    serial_valid = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset data_out",   32'(data_out),   32'h0);
    checkOutput("reset data_valid", 32'(data_valid), 32'h0);
    checkOutput("reset busy",       32'(busy),       32'h0);
    checkOutput("reset overrun",    32'(overrun),    32'h0);
    @(posedge clock);
    #1;
    serial_valid = 1'b0;
    serial_in    = 1'b1;
    reset        = 1'b1;
    idle();

    // Single word: bits 1,0,1,0,0,1,0,1 LSB first form 0xA5.
    sendWord(8'hA5, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("single data_out",   32'(data_out),   32'hA5);
    checkOutput("single data_valid", 32'(data_valid), 32'h1);
    checkOutput("single busy",       32'(busy),       32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clock);
    checkOutput("ack clears valid", 32'(data_valid), 32'h0);

    // Serializer-style traffic: strobe high for exactly W cycles per word.
    sendWord(8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("loop word0", 32'(data_out), 32'h3C);
    idle();
    sendWord(8'hFF, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("loop word1",    32'(data_out), 32'hFF);
    checkOutput("loop overrun",  32'(overrun),  32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle();

    // Truncated frame: five bits then the strobe drops.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    idle();
    idle();
    @(negedge clock);
    checkOutput("trunc frame_error", 32'(frame_error), 32'h1);
    checkOutput("trunc busy",        32'(busy),        32'h0);
    checkOutput("trunc data_valid",  32'(data_valid),  32'h0);
    idle();
    @(negedge clock);
    checkOutput("trunc pulse ends",  32'(frame_error), 32'h0);
    sendWord(8'h81, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("after trunc word", 32'(data_out), 32'h81);

    // Back-to-back words with no ack overwrite the buffer and set overrun.
    doReset();
    sendWord(8'h12, 1'b0);
    sendWord(8'h34, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("overrun data_out", 32'(data_out), 32'h34);
    checkOutput("overrun flag",     32'(overrun),  32'h1);
    idle();
    @(negedge clock);
    checkOutput("overrun sticky",   32'(overrun),  32'h1);

    // Same sequence, but the old word is acknowledged on the new word's final-bit edge.
    doReset();
    sendWord(8'h12, 1'b0);
    sendWord(8'h34, 1'b1);
    idle();
    @(negedge clock);
    checkOutput("simul data_valid", 32'(data_valid), 32'h1);
    checkOutput("simul data_out",   32'(data_out),   32'h34);
    checkOutput("simul overrun",    32'(overrun),    32'h0);

    // Reset asserted four bits into a frame takes effect without waiting for a clock.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    serial_valid = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    sendWord(8'h5A, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("post reset word",  32'(data_out),   32'h5A);
    checkOutput("post reset valid", 32'(data_valid), 32'h1);
    idle();
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
